game_ctrl: RTL and testbench
============================

// Module: game_ctrl
// PURPOSE
// Game-state controller: the consumer/driver end of the obstacle interface. Each cycle it reads
// the 8x8 obstacle grid the obstacle mover produces, together with the frog position. It
// detects collisions and goal arrival, keeps lives and level, and drives resetGame, pause and
// the one-hot level back into the obstacle mover. It sits between the frog/obstacle datapath
// and the LED-matrix/HEX display logic.
// PARAMETERS
// LIVES      3  lives loaded on start; 1..3 (fits lives[1:0])
// HIT_CYCLES 4  cycles HIT state is held before respawn/game-over; >=1
// GOAL_ROW   7  row index the frog must reach to clear a level
// PORTS
// clk        in   1     system clock
// reset      in   1     asynchronous, active-high reset
// obs        in   [7:0][7:0] obstacle grid; obs[r][c]=1 -> obstacle at row r, column c
// frogRow    in   3     frog row (0 = start row)
// frogCol    in   3     frog column
// startBtn   in   1     single-cycle pulse (already edge-detected): start/restart
// pauseBtn   in   1     single-cycle pulse: toggle pause
// resetGame  out  1     one-cycle pulse: reload obstacles and respawn frog
// pause      out  1     1 = obstacles/frog frozen
// level      out  4     one-hot level 0001,0010,0100,1000
// lives      out  2     remaining lives
// hitFlag    out  1     1 while in HIT
// gameOver   out  1     1 in OVER;  win  out 1  1 in WIN
// BEHAVIOUR
// - All outputs registered. Reset (async): state=IDLE, level=0001, lives=LIVES, resetGame=0,
//   pause=1, hitFlag=0, gameOver=0, win=0, hit timer=0.
// - States: IDLE, PLAY, PAUSED, HIT, LVLUP, OVER, WIN. pause=1 in every state except PLAY.
// - collide = obs[frogRow][frogCol] (combinational on current inputs); goal = (frogRow==GOAL_ROW).
// - IDLE: startBtn -> PLAY, resetGame=1 for the next cycle, lives=LIVES, level=0001.
// - PLAY, checked in priority order:
//   1. collide -> HIT; lives decrements the same edge; timer=HIT_CYCLES-1.
//   2. else goal -> LVLUP.
//   3. else pauseBtn -> PAUSED.
//   Transition takes effect on the edge after the condition is sampled, so pause=1 one cycle
//   after the triggering grid/position.
// - PAUSED: pauseBtn -> PLAY; startBtn -> IDLE-style restart (straight to PLAY, lives/level
//   reloaded, resetGame pulse). Collisions are ignored while PAUSED.
// - HIT: timer counts down each cycle. At timer==0:
//   - lives==0 -> OVER;
//   - else -> PLAY with a one-cycle resetGame pulse.
//   HIT always lasts exactly HIT_CYCLES cycles; pauseBtn is ignored.
// - LVLUP (1 cycle):
//   - level!=1000 -> level<<=1, resetGame pulse, -> PLAY;
//   - level==1000 -> WIN, level unchanged.
// - OVER / WIN: outputs hold. startBtn -> PLAY with lives=LIVES, level=0001, resetGame pulse.
// - resetGame is never high for more than 1 consecutive cycle. lives never wraps below 0
//   (decrement is saturating).
// - Simultaneous events: startBtn+pauseBtn in any state -> startBtn wins. collide+goal -> collide
//   wins. collide+pauseBtn -> collide wins.
// - Async reset mid-HIT or mid-LVLUP returns immediately to reset values; no resetGame pulse.
// - level is always exactly one-hot; any non-one-hot value is unreachable.
// TESTING
// 1. Reset, then startBtn -> resetGame=1 for exactly 1 cycle, state PLAY, pause=0,
//    level=0001, lives=3.
// 2. PLAY, obs[3][4]=1, frogRow=3, frogCol=4 -> next cycle hitFlag=1, pause=1, lives=2; after
//    4 cycles hitFlag=0, resetGame pulse, pause=0.
// 3. Three collisions from lives=3 -> after the third HIT (4 cycles) gameOver=1, lives=0,
//    no resetGame; startBtn -> lives=3, level=0001, PLAY.
// 4. frogRow=7 with no obstacle at level 0001,0010,0100 -> level steps 0010,0100,1000,
//    each with one resetGame pulse; at level 1000 -> win=1, level stays 1000.
// 5. pauseBtn in PLAY -> pause=1; inject collision while paused -> lives unchanged;
//    pauseBtn -> pause=0. Same-cycle pauseBtn+collide in PLAY -> HIT, lives decrements.
// 6. Assert reset for 1 cycle during HIT (timer=2) -> immediately IDLE, lives=3,
//    level=0001, pause=1, resetGame=0.

Source files
------------

// File: rtl/game_ctrl.sv
// Game-state controller for the frog game: watches the obstacle grid and frog
// position, tracks lives and level, and drives resetGame/pause/level back to the mover.
module game_ctrl #(
    parameter int LIVES      = 3,
    parameter int HIT_CYCLES = 4,
    parameter int GOAL_ROW   = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0][7:0] obs,
    input  logic [2:0]      frogRow,
    input  logic [2:0]      frogCol,
    input  logic            startBtn,
    input  logic            pauseBtn,
    output logic            resetGame,
    output logic            pause,
    output logic [3:0]      level,
    output logic [1:0]      lives,
    output logic            hitFlag,
    output logic            gameOver,
    output logic            win
);

    localparam int TW = (HIT_CYCLES > 1) ? $clog2(HIT_CYCLES) : 1;
    localparam logic [1:0]    LIVES_INIT = 2'(LIVES);
    localparam logic [TW-1:0] TIMER_INIT = TW'(HIT_CYCLES - 1);
    localparam logic [2:0]    GOAL       = 3'(GOAL_ROW);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PLAY   = 3'd1,
        S_PAUSED = 3'd2,
        S_HIT    = 3'd3,
        S_LVLUP  = 3'd4,
        S_OVER   = 3'd5,
        S_WIN    = 3'd6
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          collide;
    logic          goal;

    assign collide = obs[frogRow][frogCol];
    assign goal    = (frogRow == GOAL);

    // Game FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            level     <= 4'b0001;
            lives     <= LIVES_INIT;
            timer     <= '0;
            resetGame <= 1'b0;
            pause     <= 1'b1;
            hitFlag   <= 1'b0;
            gameOver  <= 1'b0;
            win       <= 1'b0;
        end else begin
            resetGame <= 1'b0;
            case (state)
                S_IDLE, S_OVER, S_WIN, S_PAUSED: begin
                    if (startBtn) begin
                        state     <= S_PLAY;
                        resetGame <= 1'b1;
                        pause     <= 1'b0;
                        lives     <= LIVES_INIT;
                        level     <= 4'b0001;
                        gameOver  <= 1'b0;
                        win       <= 1'b0;
                    end else if (state == S_PAUSED && pauseBtn) begin
                        state <= S_PLAY;
                        pause <= 1'b0;
                    end
                end
                S_PLAY: begin
                    // Collision outranks goal, restart and pause in the same cycle.
                    if (collide) begin
                        state   <= S_HIT;
                        pause   <= 1'b1;
                        hitFlag <= 1'b1;
                        lives   <= (lives != 2'd0) ? lives - 2'd1 : 2'd0;
                        timer   <= TIMER_INIT;
                    end else if (goal) begin
                        state <= S_LVLUP;
                        pause <= 1'b1;
                    end else if (startBtn) begin
                        resetGame <= 1'b1;
                        lives     <= LIVES_INIT;
                        level     <= 4'b0001;
                    end else if (pauseBtn) begin
                        state <= S_PAUSED;
                        pause <= 1'b1;
                    end
                end
                S_HIT: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else if (lives == 2'd0) begin
                        state    <= S_OVER;
                        hitFlag  <= 1'b0;
                        gameOver <= 1'b1;
                    end else begin
                        state     <= S_PLAY;
                        hitFlag   <= 1'b0;
                        pause     <= 1'b0;
                        resetGame <= 1'b1;
                    end
                end
                S_LVLUP: begin
                    if (level != 4'b1000) begin
                        level     <= {level[2:0], 1'b0};
                        state     <= S_PLAY;
                        pause     <= 1'b0;
                        resetGame <= 1'b1;
                    end else begin
                        state <= S_WIN;
                        win   <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    level    <= 4'b0001;
                    lives    <= LIVES_INIT;
                    timer    <= '0;
                    pause    <= 1'b1;
                    hitFlag  <= 1'b0;
                    gameOver <= 1'b0;
                    win      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: a behavioural model predicts the registered
// outputs for every cycle; predictions are queued and compared after each edge.
module tb_game_ctrl;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [7:0][7:0] obs = '0;
    logic [2:0]      frogRow = 3'd0;
    logic [2:0]      frogCol = 3'd0;
    logic            startBtn = 1'b0;
    logic            pauseBtn = 1'b0;
    logic            resetGame;
    logic            pause;
    logic [3:0]      level;
    logic [1:0]      lives;
    logic            hitFlag;
    logic            gameOver;
    logic            win;

    int total = 0;
    int bad   = 0;

    // model state: 0 IDLE,1 PLAY,2 PAUSED,3 HIT,4 LVLUP,5 OVER,6 WIN
    int m_st, m_lvl, m_lives, m_timer;
    bit m_rg;
    logic [10:0] exp_q[$];

    game_ctrl dut (
        .clk(clk), .reset(reset), .obs(obs), .frogRow(frogRow), .frogCol(frogCol),
        .startBtn(startBtn), .pauseBtn(pauseBtn), .resetGame(resetGame), .pause(pause),
        .level(level), .lives(lives), .hitFlag(hitFlag), .gameOver(gameOver), .win(win)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] dut_vec();
        return {resetGame, pause, level, lives, hitFlag, gameOver, win};
    endfunction

    function automatic logic [10:0] model_vec();
        logic [3:0] lv;
        lv = 4'b0001 << m_lvl;
        return {m_rg, (m_st != 1), lv, 2'(m_lives), (m_st == 3), (m_st == 5), (m_st == 6)};
    endfunction

    task automatic model_reset();
        m_st = 0; m_lvl = 0; m_lives = 3; m_timer = 0; m_rg = 1'b0;
    endtask

    task automatic model_restart();
        m_st = 1; m_lvl = 0; m_lives = 3; m_rg = 1'b1;
    endtask

    task automatic model_step();
        bit col, gl;
        col  = obs[frogRow][frogCol];
        gl   = (frogRow == 3'd7);
        m_rg = 1'b0;
        case (m_st)
            0, 5, 6: if (startBtn) model_restart();
            1: begin
                if (col) begin
                    m_st = 3; m_timer = 3;
                    if (m_lives > 0) m_lives--;
                end else if (gl) m_st = 4;
                else if (startBtn) model_restart();
                else if (pauseBtn) m_st = 2;
            end
            2: begin
                if (startBtn) model_restart();
                else if (pauseBtn) m_st = 1;
            end
            3: begin
                if (m_timer > 0) m_timer--;
                else if (m_lives == 0) m_st = 5;
                else begin m_st = 1; m_rg = 1'b1; end
            end
            4: begin
                if (m_lvl < 3) begin m_lvl++; m_st = 1; m_rg = 1'b1; end
                else m_st = 6;
            end
            default: model_reset();
        endcase
    endtask

    // Predict, let the DUT take one edge, then score the oldest prediction.
    task automatic tick(input string tag);
        if (reset) model_reset();
        else model_step();
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
        check_val(tag, 16'(dut_vec()), 16'(exp_q.pop_front()));
    endtask

    task automatic hit_cycle(input logic [2:0] r, input logic [2:0] c, input string tag);
        obs = '0; obs[r][c] = 1'b1; frogRow = r; frogCol = c;
        tick(tag);
        obs = '0; frogRow = 3'd0; frogCol = 3'd0;
        repeat (4) tick({tag, "_hold"});
        tick({tag, "_after"});
    endtask

    initial begin
        model_reset();
        tick("reset_a");
        tick("reset_b");
        check_val("reset_lives", 16'(lives), 16'd3);
        check_val("reset_pause", 16'(pause), 16'd1);
        reset = 1'b0;

        // start from IDLE
        startBtn = 1'b1; tick("start");
        startBtn = 1'b0;
        check_val("start_rg", 16'(resetGame), 16'd1);
        tick("start_rg_drop");
        check_val("start_rg_low", 16'(resetGame), 16'd0);

        // first collision
        hit_cycle(3'd3, 3'd4, "hit1");
        check_val("hit1_lives", 16'(lives), 16'd2);
        // two more collisions drain lives and end the game
        hit_cycle(3'd3, 3'd4, "hit2");
        hit_cycle(3'd1, 3'd6, "hit3");
        check_val("over_flag", 16'(gameOver), 16'd1);
        check_val("over_lives", 16'(lives), 16'd0);
        tick("over_hold");

        // start and pause together: start wins
        startBtn = 1'b1; pauseBtn = 1'b1; tick("restart_over");
        startBtn = 1'b0; pauseBtn = 1'b0;
        check_val("restart_lives", 16'(lives), 16'd3);

        // climb through every level to WIN
        for (int i = 0; i < 4; i++) begin
            frogRow = 3'd7; frogCol = 3'(i);
            tick("goal");
            frogRow = 3'd0;
            tick("lvlup");
        end
        check_val("win_flag", 16'(win), 16'd1);
        check_val("win_level", 16'(level), 16'b1000);
        tick("win_hold");
        startBtn = 1'b1; tick("restart_win");
        startBtn = 1'b0;
        check_val("restart_level", 16'(level), 16'b0001);

        // collide together with goal: collide wins
        hit_cycle(3'd7, 3'd2, "hit_goal");

        // pause, ignored collision, resume
        pauseBtn = 1'b1; tick("pause_on");
        pauseBtn = 1'b0;
        obs[3][4] = 1'b1; frogRow = 3'd3; frogCol = 3'd4;
        tick("paused_col_a");
        tick("paused_col_b");
        check_val("paused_lives", 16'(lives), 16'd2);
        obs = '0; frogRow = 3'd0;
        pauseBtn = 1'b1; tick("pause_off");
        pauseBtn = 1'b0;
        check_val("resume_pause", 16'(pause), 16'd0);

        // pause and collide together: collide wins, then reset mid-HIT
        obs[5][5] = 1'b1; frogRow = 3'd5; frogCol = 3'd5; pauseBtn = 1'b1;
        tick("hit_pause");
        pauseBtn = 1'b0; obs = '0; frogRow = 3'd0; frogCol = 3'd0;
        check_val("hit_pause_lives", 16'(lives), 16'd1);
        tick("hit_t2");
        reset = 1'b1;
        #1;
        model_reset();
        check_val("async_reset", 16'(dut_vec()), 16'(model_vec()));
        tick("reset_held");
        reset = 1'b0;
        tick("idle_after");
        startBtn = 1'b1; tick("final_start");
        startBtn = 1'b0;
        tick("final_play");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
